// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory slave.
//   - default widths, depth, latency and out-of-range read data
//   - cmd_e   : command decoded from {wr, rd}
//   - rsp_t   : one response pipeline slot {valid, is_read, err, data}
//   - decode_cmd : {wr, rd} -> cmd_e
package mem_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_SIZE   = 16;
  localparam int DEF_RD_LATENCY = 2;
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  // Encoding matches the {wr, rd} bit pair so decode is a plain cast.
  typedef enum logic [1:0] {
    CMD_IDLE    = 2'b00,
    CMD_RD      = 2'b01,
    CMD_WR      = 2'b10,
    CMD_COLLIDE = 2'b11
  } cmd_e;

  typedef struct packed {
    logic                      valid;
    logic                      is_read;
    logic                      err;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rsp_t;

  function automatic cmd_e decode_cmd(input logic wr, input logic rd);
    return cmd_e'({wr, rd});
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// mem_rsp_pipe: DEPTH-deep shift register of response slots.
// The last stage is the response output register: its valid/err fields
// follow the previous stage every edge, while its data field only loads
// on a valid read so the read data holds across write responses and idle
// cycles.
// Ports:
//   clk     : clock, all state on posedge
//   reset   : asynchronous active-low flush of every stage
//   rsp_in  : slot entering the pipe at each posedge
//   rsp_out : output register contents
module mem_rsp_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_RD_LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  rsp_t rsp_in,
  output rsp_t rsp_out
);

  rsp_t stage [DEPTH];
  rsp_t prev  [DEPTH];

  // prev[i] is whatever stage[i] loads at the next edge.
  always_comb begin
    prev[0] = rsp_in;
    for (int i = 1; i < DEPTH; i++) begin
      prev[i] = stage[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        stage[i] <= prev[i];
      end
      stage[DEPTH-1].valid   <= prev[DEPTH-1].valid;
      stage[DEPTH-1].is_read <= prev[DEPTH-1].is_read;
      stage[DEPTH-1].err     <= prev[DEPTH-1].err;
      if (prev[DEPTH-1].valid && prev[DEPTH-1].is_read) begin
        stage[DEPTH-1].data <= prev[DEPTH-1].data;
      end
    end
  end

  assign rsp_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_slave.sv
// mem_slave: register-array memory slave with a fixed-latency, in-order
// response for every accepted command.
// Ports:
//   clk     : clock, all state on posedge
//   reset   : asynchronous active-low reset (clears array and responses)
//   wr, rd  : command strobes sampled at posedge (both set = collision)
//   addr    : word address, compared unsigned against MEM_SIZE
//   wdata   : write data
//   rdata   : read data of the most recent read response (held otherwise)
//   slv_rsp : one-cycle pulse per accepted command
//   err     : one-cycle pulse with slv_rsp for collision / out-of-range
module mem_slave
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    MEM_SIZE   = DEF_MEM_SIZE,
  parameter int                    RD_LATENCY = DEF_RD_LATENCY,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DEF_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slv_rsp,
  output logic                  err
);

  // rsp_t carries data at the package width, so the data path is fixed to it.
  if (DATA_WIDTH != DEF_DATA_WIDTH) begin : g_bad_width
    $error("mem_slave: DATA_WIDTH must equal mem_pkg::DEF_DATA_WIDTH");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
    $error("mem_slave: RD_LATENCY must be within 1..8");
  end
  if (MEM_SIZE < 1 || MEM_SIZE > (1 << ADDR_WIDTH)) begin : g_bad_size
    $error("mem_slave: MEM_SIZE must be within 1..2**ADDR_WIDTH");
  end

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  // One extra bit so MEM_SIZE == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  cmd_e             cmd;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             do_write;
  rsp_t             rsp_in;
  rsp_t             rsp_out;

  always_comb begin
    cmd      = decode_cmd(wr, rd);
    in_range = {1'b0, addr} < MEM_LIMIT;
    idx      = addr[IDX_W-1:0];
    do_write = ((cmd == CMD_WR) || (cmd == CMD_COLLIDE)) && in_range;

    rsp_in         = '0;
    rsp_in.valid   = (cmd != CMD_IDLE);
    // A collision performs only the write, so it never loads rdata.
    rsp_in.is_read = (cmd == CMD_RD);
    rsp_in.err     = (cmd == CMD_COLLIDE) || ((cmd != CMD_IDLE) && !in_range);
    if (cmd == CMD_RD) begin
      // Snapshot taken from the pre-edge array; later writes cannot
      // disturb a read already in flight.
      rsp_in.data = in_range ? mem[idx] : ERR_DATA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[idx] <= wdata;
    end
  end

  mem_rsp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rsp_pipe (
    .clk     (clk),
    .reset   (reset),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign slv_rsp = rsp_out.valid;
  assign err     = rsp_out.err;
  assign rdata   = rsp_out.data;

endmodule
